// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
// Tie policy is selected by ARB_ROUND_ROBIN_EN (undefined: dcache wins ties).
package constants_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  localparam logic ARB_ICACHE = 1'b0;
  localparam logic ARB_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache <-> memory request/response bus.
// Modports are named for the party on the far side of the holder.
interface data_bus;
  import constants_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              ldp;
  logic              srp;
  logic [DATA_W-1:0] srData;
  logic [DATA_W-1:0] ldData;
  logic              ldr;
  logic              srr;

  modport producer (
    input  addr, ldp, srp, srData,
    output ldData, ldr, srr
  );

  modport consumer (
    output addr, ldp, srp, srData,
    input  ldData, ldr, srr
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Two-way winner select for the memory arbiter.
// ARB_ROUND_ROBIN_EN: tie goes to the requester other than last.
module arb_pick
  import constants_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (&req) begin
      win = '0;
`ifdef ARB_ROUND_ROBIN_EN
      win[~last] = 1'b1;
`else
      win[ARB_DCACHE] = 1'b1;
`endif
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache refill and dcache refill/writeback.
// Policy macro ARB_ROUND_ROBIN_EN (see arb_pick); default is fixed priority.
module mem_arbiter
  import constants_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_bus.producer       ibus,
  data_bus.producer       dbus,
  data_bus.consumer       mbus,
  output logic [NREQ-1:0] grant
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] req;
  logic [1:0] win;
  logic       ack;

  // icache is load-only, so its srp never counts as a request
  assign req[ARB_ICACHE] = ibus.ldp;
  assign req[ARB_DCACHE] = dbus.ldp | dbus.srp;
  assign ack = mbus.ldr | mbus.srr;

  arb_pick u_pick (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= ARB_DCACHE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE, RELEASE: begin
        unique case (1'b1)
          win[ARB_ICACHE]: state_d = GRANT_I;
          win[ARB_DCACHE]: state_d = GRANT_D;
          default:         state_d = IDLE;
        endcase
      end
      GRANT_I: begin
        if (ack) begin
          state_d = RELEASE;
          last_d  = ARB_ICACHE;
        end
      end
      GRANT_D: begin
        if (ack) begin
          state_d = RELEASE;
          last_d  = ARB_DCACHE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ibus.ldData = mbus.ldData;
  assign dbus.ldData = mbus.ldData;

  always_comb begin
    grant       = '0;
    mbus.addr   = '0;
    mbus.ldp    = 1'b0;
    mbus.srp    = 1'b0;
    mbus.srData = '0;
    ibus.ldr    = 1'b0;
    ibus.srr    = 1'b0;
    dbus.ldr    = 1'b0;
    dbus.srr    = 1'b0;
    unique case (state_q)
      GRANT_I: begin
        grant[ARB_ICACHE] = 1'b1;
        mbus.addr = ibus.addr;
        mbus.ldp  = ibus.ldp;
        ibus.ldr  = mbus.ldr;
      end
      GRANT_D: begin
        grant[ARB_DCACHE] = 1'b1;
        mbus.addr   = dbus.addr;
        mbus.ldp    = dbus.ldp;
        mbus.srp    = dbus.srp;
        mbus.srData = dbus.srData;
        dbus.ldr    = mbus.ldr;
        dbus.srr    = mbus.srr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with an 8-cycle behavioral memory.
// Expected ack order/timing depends on ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
  import constants_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  data_bus ib ();
  data_bus db ();
  data_bus mb ();

  mem_arbiter #(.NREQ(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .ibus  (ib),
    .dbus  (db),
    .mbus  (mb),
    .grant (grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] line(input int i);
    return {4{32'hA000_0000 | 32'(i)}};
  endfunction

  // behavioral memory: request seen at a clock edge, response 8 cycles
  // after the grant cycle, single-cycle ldr/srr
  logic [127:0] mem [0:63];
  logic         m_busy;
  logic [3:0]   m_cnt;
  logic [5:0]   m_idx;
  logic         m_ld, m_st;
  logic [127:0] m_wd;
  logic         m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_idx  <= '0;
      m_ld   <= 1'b0;
      m_st   <= 1'b0;
      m_wd   <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= line(i);
    end else if (!m_busy) begin
      if (mb.ldp || mb.srp) begin
        m_busy <= 1'b1;
        m_cnt  <= 4'd1;
        m_idx  <= mb.addr[9:4];
        m_ld   <= mb.ldp;
        m_st   <= mb.srp;
        m_wd   <= mb.srData;
      end
    end else if (m_cnt == 4'd8) begin
      m_busy <= 1'b0;
      if (m_st) mem[m_idx] <= m_wd;
    end else begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  assign m_done    = m_busy && (m_cnt == 4'd8);
  assign mb.ldr    = m_done && m_ld;
  assign mb.srr    = m_done && m_st;
  assign mb.ldData = m_done ? mem[m_idx] : '0;

  typedef struct {
    int           port;
    bit           st;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int           m_port;
  bit           m_stg;
  logic [127:0] m_data;

  task automatic push(input int p, input bit st, input logic [127:0] d,
                      input int c);
    exp_t e;
    e.port = p;
    e.st   = st;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ib.ldr || ib.srr || db.ldr || db.srr) begin
      checks++;
      m_port = (db.ldr || db.srr) ? 1 : 0;
      m_stg  = ib.srr || db.srr;
      m_data = m_port == 1 ? db.ldData : ib.ldData;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack cyc=%0d port=%0d", cyc, m_port);
      end else begin
        me = exp_q.pop_front();
        if (m_port != me.port || m_stg != me.st || cyc != me.cyc ||
            (!me.st && m_data !== me.data) ||
            grant !== (2'b01 << me.port)) begin
          errors++;
          $display("FAIL ack got port=%0d st=%0d cyc=%0d grant=%b data=%h want port=%0d st=%0d cyc=%0d data=%h",
                   m_port, m_stg, cyc, grant, m_data,
                   me.port, me.st, me.cyc, me.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input int p, input logic ld, input logic st,
                       input logic [31:0] a, input logic [127:0] d);
    if (p == 0) begin
      ib.ldp = ld; ib.srp = st; ib.addr = a; ib.srData = d;
    end else begin
      db.ldp = ld; db.srp = st; db.addr = a; db.srData = d;
    end
  endtask

  function automatic logic acked(input int p);
    return p == 0 ? (ib.ldr | ib.srr) : (db.ldr | db.srr);
  endfunction

  // holds the request across n back-to-back transactions
  task automatic burst(input int p, input int n, input logic [31:0] a0,
                       input logic st, input logic [127:0] d);
    int got;
    int w;
    got = 0;
    w = 0;
    drive(p, !st, st, a0, d);
    while (got < n && w < 500) begin
      @(negedge clk);
      w++;
      if (acked(p)) begin
        got++;
        @(posedge clk);
        #1;
        if (got < n) drive(p, !st, st, a0 + 32'(got * 16), d);
        else drive(p, 1'b0, 1'b0, '0, '0);
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout port=%0d got=%0d want=%0d", p, got, n);
      drive(p, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic start(output int n0);
    @(posedge clk);
    #1;
    n0 = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  localparam logic [127:0] SDATA = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  initial begin
    int n0;
    int w;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rst_grant", 128'(grant), 128'(2'b00));
    chk("rst_mbus_req", 128'({mb.ldp, mb.srp}), 128'(2'b00));
    chk("rst_mbus_addr", 128'(mb.addr), 128'(0));
    chk("rst_acks", 128'({ib.ldr, ib.srr, db.ldr, db.srr}), 128'(4'b0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single icache load
    start(n0);
    push(0, 1'b0, line(1), n0 + 9);
    fork
      burst(0, 1, 32'h10, 1'b0, '0);
      begin
        @(negedge clk);
        chk("grant_cycle0", 128'(grant), 128'(2'b00));
        @(negedge clk);
        chk("grant_cycle1", 128'(grant), 128'(2'b01));
        chk("mbus_addr_c1", 128'(mb.addr), 128'(32'h10));
        chk("mbus_ldp_c1", 128'(mb.ldp), 128'(1'b1));
      end
    join

    // dcache store then load back
    start(n0);
    push(1, 1'b1, '0, n0 + 9);
    burst(1, 1, 32'h20, 1'b1, SDATA);
    start(n0);
    push(1, 1'b0, SDATA, n0 + 9);
    burst(1, 1, 32'h20, 1'b0, '0);

    // icache store request is ignored
    ib.srp = 1'b1;
    ib.addr = 32'h30;
    repeat (6) begin
      @(negedge clk);
      chk("isrp_grant", 128'(grant), 128'(2'b00));
      chk("isrp_srr", 128'(ib.srr), 128'(1'b0));
    end
    ib.srp = 1'b0;
    repeat (2) @(negedge clk);

    // simultaneous loads from reset
    do_reset();
    start(n0);
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 1'b0, line(3), n0 + 9);
    push(1, 1'b0, line(4), n0 + 19);
`else
    push(1, 1'b0, line(4), n0 + 9);
    push(0, 1'b0, line(3), n0 + 19);
`endif
    fork
      burst(0, 1, 32'h30, 1'b0, '0);
      burst(1, 1, 32'h40, 1'b0, '0);
    join

    // continuous contention
    do_reset();
    start(n0);
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 1'b0, line(5), n0 + 9);
    push(1, 1'b0, line(7), n0 + 19);
    push(0, 1'b0, line(6), n0 + 29);
    push(1, 1'b0, line(8), n0 + 39);
    fork
      burst(0, 2, 32'h50, 1'b0, '0);
      burst(1, 2, 32'h70, 1'b0, '0);
    join
`else
    push(1, 1'b0, line(7), n0 + 9);
    push(1, 1'b0, line(8), n0 + 19);
    push(1, 1'b0, line(9), n0 + 29);
    push(1, 1'b0, line(10), n0 + 39);
    push(0, 1'b0, line(5), n0 + 49);
    fork
      burst(0, 1, 32'h50, 1'b0, '0);
      burst(1, 4, 32'h70, 1'b0, '0);
    join
`endif

    // reset in cycle 5 of a grant
    repeat (2) @(negedge clk);
    start(n0);
    drive(0, 1'b1, 1'b0, 32'h90, '0);
    repeat (6) @(negedge clk);
    chk("pre_rst_grant", 128'(grant), 128'(2'b01));
    rst = 1'b0;
    #1;
    chk("midrst_grant", 128'(grant), 128'(2'b00));
    chk("midrst_mbus_req", 128'({mb.ldp, mb.srp}), 128'(2'b00));
    chk("midrst_mbus_addr", 128'(mb.addr), 128'(0));
    chk("midrst_acks", 128'({ib.ldr, ib.srr, db.ldr, db.srr}), 128'(4'b0));
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    start(n0);
    push(0, 1'b0, line(1), n0 + 9);
    burst(0, 1, 32'h10, 1'b0, '0);

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    while (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_ack got=none want port=%0d cyc=%0d",
               me.port, me.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
